// File: rtl/y86_execute_stage_pkg.sv
// Shared definitions for the Y86-64 execute stage: datapath width, icode and
// ifun encodings, ALU function enum and condition-code bit positions.
package y86_execute_stage_pkg;

  localparam int unsigned DATA_WID  = 64;
  // Stack-pointer adjustment; 8 bytes regardless of datapath width.
  localparam int unsigned STACK_ADJ = 8;

  // Instruction codes.
  localparam logic [3:0] _HALT   = 4'h0;
  localparam logic [3:0] _NOP    = 4'h1;
  localparam logic [3:0] _CMOVXX = 4'h2;
  localparam logic [3:0] _IRMOV  = 4'h3;
  localparam logic [3:0] _RMMOV  = 4'h4;
  localparam logic [3:0] _MRMOV  = 4'h5;
  localparam logic [3:0] _OP     = 4'h6;
  localparam logic [3:0] _JXX    = 4'h7;
  localparam logic [3:0] _CALL   = 4'h8;
  localparam logic [3:0] _RET    = 4'h9;
  localparam logic [3:0] _PUSH   = 4'hA;
  localparam logic [3:0] _POP    = 4'hB;

  // OP function codes.
  localparam logic [3:0] _Add = 4'h0;
  localparam logic [3:0] _Sub = 4'h1;
  localparam logic [3:0] _And = 4'h2;
  localparam logic [3:0] _Xor = 4'h3;

  // Condition selectors for CMOVXX / JXX.
  localparam logic [3:0] NonCond = 4'h0;
  localparam logic [3:0] REL_LE  = 4'h1;
  localparam logic [3:0] REL_L   = 4'h2;
  localparam logic [3:0] REL_E   = 4'h3;
  localparam logic [3:0] REL_NE  = 4'h4;
  localparam logic [3:0] REL_GE  = 4'h5;
  localparam logic [3:0] REL_G   = 4'h6;

  // Condition-code bit indices.
  localparam int unsigned CC_ZF = 0;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 2;
  localparam int unsigned CC_CF = 3;

  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluSub = 2'd1,
    AluAnd = 2'd2,
    AluXor = 2'd3
  } alu_fun_e;

endpackage

// File: rtl/y86_alu_core.sv
// Combinational Y86 ALU: result = B op A for Add/Sub/And/Xor, plus flags.
// Ports:
//   alu_a_i, alu_b_i  operands (Sub computes B minus A)
//   alu_fun_i         2-bit function select
//   result_o          ALU result, modulo 2^DATA_WID
//   zf_o, sf_o, of_o  zero / sign / signed-overflow flags
//   cf_o              carry (Add) or borrow (Sub); only built with ALU_CARRY_EN,
//                     otherwise tied to 0
module y86_alu_core #(
  parameter int unsigned DATA_WID = y86_execute_stage_pkg::DATA_WID
) (
  input  logic [DATA_WID-1:0]                   alu_a_i,
  input  logic [DATA_WID-1:0]                   alu_b_i,
  input  y86_execute_stage_pkg::alu_fun_e       alu_fun_i,
  output logic [DATA_WID-1:0]                   result_o,
  output logic                                  zf_o,
  output logic                                  sf_o,
  output logic                                  of_o,
  output logic                                  cf_o
);
  import y86_execute_stage_pkg::*;

  logic [DATA_WID-1:0] add_res;
  logic                a_neg, b_neg, r_neg;

`ifdef ALU_CARRY_EN
  // One extra bit on the adder exposes the carry-out.
  logic [DATA_WID:0] sum_ext;
  assign sum_ext = {1'b0, alu_b_i} + {1'b0, alu_a_i};
  assign add_res = sum_ext[DATA_WID-1:0];

  always_comb begin
    cf_o = 1'b0;
    case (alu_fun_i)
      AluAdd:  cf_o = sum_ext[DATA_WID];
      AluSub:  cf_o = (alu_b_i < alu_a_i);
      default: cf_o = 1'b0;
    endcase
  end
`else
  assign add_res = alu_b_i + alu_a_i;
  assign cf_o    = 1'b0;
`endif

  always_comb begin
    result_o = '0;
    case (alu_fun_i)
      AluAdd:  result_o = add_res;
      AluSub:  result_o = alu_b_i - alu_a_i;
      AluAnd:  result_o = alu_b_i & alu_a_i;
      default: result_o = alu_b_i ^ alu_a_i;
    endcase
  end

  assign a_neg = alu_a_i[DATA_WID-1];
  assign b_neg = alu_b_i[DATA_WID-1];
  assign r_neg = result_o[DATA_WID-1];

  assign zf_o = (result_o == '0);
  assign sf_o = r_neg;

  always_comb begin
    of_o = 1'b0;
    case (alu_fun_i)
      AluAdd:  of_o = (a_neg == b_neg) && (r_neg != a_neg);
      // B - A overflows when the operands differ in sign and the result
      // sign departs from the minuend B.
      AluSub:  of_o = (a_neg != b_neg) && (r_neg != b_neg);
      default: of_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU operand muxes, ALU function decode, condition
// code register and branch/cmov condition evaluation.
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset (clears cc)
//   icode, ifun        instruction and function codes from decode
//   valA, valB, valC   register operands and instruction constant
//   valE               ALU result, combinational
//   cc                 registered flags {CF, OF, SF, ZF}; updated on OP only
//   cnd                condition from registered cc, combinational
// Optional feature: define ALU_CARRY_EN to build the carry/borrow flag into
// cc[3]; without it cc[3] is constant 0. cnd never looks at CF.
module y86_execute_stage #(
  parameter int unsigned DATA_WID = y86_execute_stage_pkg::DATA_WID
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          icode,
  input  logic [3:0]          ifun,
  input  logic [DATA_WID-1:0] valA,
  input  logic [DATA_WID-1:0] valB,
  input  logic [DATA_WID-1:0] valC,
  output logic [DATA_WID-1:0] valE,
  output logic [3:0]          cc,
  output logic                cnd
);
  import y86_execute_stage_pkg::*;

  localparam logic [DATA_WID-1:0] StackStep = DATA_WID'(STACK_ADJ);

  logic [DATA_WID-1:0] alu_a, alu_b;
  alu_fun_e            alu_fun;
  logic                set_cc;
  logic                alu_zf, alu_sf, alu_of, alu_cf;
  logic [3:0]          cc_d, cc_q;
  logic                sf_xor_of;

  always_comb begin
    alu_a = '0;
    case (icode)
      _CMOVXX, _OP:          alu_a = valA;
      _IRMOV, _RMMOV, _MRMOV: alu_a = valC;
      _CALL, _PUSH:          alu_a = '0 - StackStep;
      _RET, _POP:            alu_a = StackStep;
      default:               alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (icode)
      _RMMOV, _MRMOV, _OP, _CALL, _RET, _PUSH, _POP: alu_b = valB;
      default:                                       alu_b = '0;
    endcase
  end

  // ifun[3:2] is ignored when selecting the OP function.
  assign alu_fun = (icode == _OP) ? alu_fun_e'(ifun[1:0]) : AluAdd;
  assign set_cc  = (icode == _OP);

  y86_alu_core #(
    .DATA_WID (DATA_WID)
  ) u_alu_core (
    .alu_a_i   (alu_a),
    .alu_b_i   (alu_b),
    .alu_fun_i (alu_fun),
    .result_o  (valE),
    .zf_o      (alu_zf),
    .sf_o      (alu_sf),
    .of_o      (alu_of),
    .cf_o      (alu_cf)
  );

  always_comb begin
    cc_d        = '0;
    cc_d[CC_ZF] = alu_zf;
    cc_d[CC_SF] = alu_sf;
    cc_d[CC_OF] = alu_of;
    cc_d[CC_CF] = alu_cf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= '0;
    end else if (set_cc) begin
      cc_q <= cc_d;
    end
  end

  assign cc = cc_q;

  assign sf_xor_of = cc_q[CC_SF] ^ cc_q[CC_OF];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      NonCond: cnd = 1'b1;
      REL_LE:  cnd = sf_xor_of | cc_q[CC_ZF];
      REL_L:   cnd = sf_xor_of;
      REL_E:   cnd = cc_q[CC_ZF];
      REL_NE:  cnd = ~cc_q[CC_ZF];
      REL_GE:  cnd = ~sf_xor_of;
      REL_G:   cnd = ~sf_xor_of & ~cc_q[CC_ZF];
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_y86_execute_stage.sv
// Bench for y86_execute_stage: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the execute stage.
module tb_y86_execute_stage;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   icode, ifun;
  logic [W-1:0] valA, valB, valC;
  logic [W-1:0] valE;
  logic [3:0]   cc;
  logic         cnd;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state.
  logic [3:0]   model_cc;
  logic [W-1:0] exp_e;
  logic [3:0]   exp_fl;
  logic         exp_upd;
  logic         exp_cnd;

  always #5 clk = ~clk;

  y86_execute_stage #(
    .DATA_WID (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icode (icode),
    .ifun  (ifun),
    .valA  (valA),
    .valB  (valB),
    .valC  (valC),
    .valE  (valE),
    .cc    (cc),
    .cnd   (cnd)
  );

  // Reference: operand choice, wide signed arithmetic for overflow,
  // unsigned wrap/compare for carry.
  function automatic void ref_alu(input logic [3:0] ic, input logic [3:0] fn,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] c, output logic [W-1:0] e,
                                  output logic [3:0] fl, output logic upd);
    logic [W-1:0]          opa, opb;
    logic signed [W+1:0]   wide;
    logic                  of, cf;
    int                    f;
    opa = '0;
    opb = '0;
    case (ic)
      4'h2, 4'h6:       opa = a;
      4'h3, 4'h4, 4'h5: opa = c;
      4'h8, 4'hA:       opa = -64'sd8;
      4'h9, 4'hB:       opa = 64'd8;
      default:          opa = '0;
    endcase
    if (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) opb = b;
    f   = (ic == 4'h6) ? int'(fn % 4) : 0;
    of  = 1'b0;
    cf  = 1'b0;
    e   = '0;
    case (f)
      0: begin
        e    = opb + opa;
        wide = $signed({{2{opb[W-1]}}, opb}) + $signed({{2{opa[W-1]}}, opa});
        of   = (wide != $signed({{2{e[W-1]}}, e}));
        cf   = (e < opb);
      end
      1: begin
        e    = opb - opa;
        wide = $signed({{2{opb[W-1]}}, opb}) - $signed({{2{opa[W-1]}}, opa});
        of   = (wide != $signed({{2{e[W-1]}}, e}));
        cf   = (opb < opa);
      end
      2: e = opb & opa;
      default: e = opb ^ opa;
    endcase
`ifndef ALU_CARRY_EN
    cf = 1'b0;
`endif
    fl  = {cf, of, e[W-1], (e == '0)};
    upd = (ic == 4'h6);
  endfunction

  function automatic logic ref_cnd(input logic [3:0] flags, input logic [3:0] fn);
    logic zf, sf, of, lt;
    zf = flags[0];
    sf = flags[1];
    of = flags[2];
    lt = (sf != of);
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return lt || zf;
      4'd2:    return lt;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !lt;
      4'd6:    return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one instruction mid-cycle and evaluate the model.
  task automatic step(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] c);
    @(negedge clk);
    icode = ic;
    ifun  = fn;
    valA  = a;
    valB  = b;
    valC  = c;
    ref_alu(ic, fn, a, b, c, exp_e, exp_fl, exp_upd);
    exp_cnd = ref_cnd(model_cc, fn);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_upd) model_cc = exp_fl;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    model_cc = '0;
    icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0;
    #3;
    n_cmp++;
    if (cc !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_cc got %b want 0000", cc);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    step(4'h6, 4'h0, 64'd3, 64'd5, 64'd0);
    n_cmp++;
    if (valE !== 64'd8) begin n_fail++; $display("FAIL add_valE got %0h want 8", valE); end
    tick();
    n_cmp++;
    if (cc !== 4'b0000) begin n_fail++; $display("FAIL add_cc got %b want 0000", cc); end
  endtask

  task automatic test_sub();
    step(4'h6, 4'h1, 64'd4, 64'd10, 64'd0);
    n_cmp++;
    if (valE !== 64'd6) begin n_fail++; $display("FAIL sub_pos_valE got %0h want 6", valE); end
    tick();
    step(4'h6, 4'h1, 64'd10, 64'd4, 64'd0);
    n_cmp++;
    if (valE !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      n_fail++;
      $display("FAIL sub_neg_valE got %0h want fffffffffffffffa", valE);
    end
    tick();
    n_cmp++;
    if (cc[2:0] !== 3'b010) begin n_fail++; $display("FAIL sub_neg_flags got %b want 010", cc[2:0]); end
    n_cmp++;
    if (cc !== model_cc) begin n_fail++; $display("FAIL sub_neg_cc got %b want %b", cc, model_cc); end
  endtask

  task automatic test_and();
    step(4'h6, 4'h2, 64'd1, 64'd2, 64'd0);
    n_cmp++;
    if (valE !== 64'd0) begin n_fail++; $display("FAIL and_valE got %0h want 0", valE); end
    tick();
    n_cmp++;
    if (cc !== 4'b0001) begin n_fail++; $display("FAIL and_cc got %b want 0001", cc); end
  endtask

  task automatic test_stack_imm();
    step(4'hA, 4'h0, 64'd99, 64'd64, 64'd7);
    n_cmp++;
    if (valE !== 64'd56) begin n_fail++; $display("FAIL push_valE got %0d want 56", valE); end
    tick();
    step(4'hB, 4'h0, 64'd99, 64'd32, 64'd7);
    n_cmp++;
    if (valE !== 64'd40) begin n_fail++; $display("FAIL pop_valE got %0d want 40", valE); end
    tick();
    step(4'h3, 4'h0, 64'h1234, 64'h5678, 64'd16);
    n_cmp++;
    if (valE !== 64'd16) begin n_fail++; $display("FAIL irmov_valE got %0d want 16", valE); end
    tick();
    n_cmp++;
    if (cc !== 4'b0001) begin n_fail++; $display("FAIL irmov_cc_hold got %b want 0001", cc); end
  endtask

  task automatic test_cond();
    step(4'h6, 4'h1, 64'd5, 64'd4, 64'd0);
    tick();
    n_cmp++;
    if (cc[2:0] !== 3'b010) begin n_fail++; $display("FAIL cond_setup got %b want 010", cc[2:0]); end
    step(4'h2, 4'h3, 64'd2, 64'd77, 64'd0);
    n_cmp++;
    if (valE !== 64'd2 || cnd !== 1'b0) begin
      n_fail++;
      $display("FAIL cmov_e got valE=%0d cnd=%b want 2/0", valE, cnd);
    end
    step(4'h2, 4'h2, 64'd4, 64'd77, 64'd0);
    n_cmp++;
    if (valE !== 64'd4 || cnd !== 1'b1) begin
      n_fail++;
      $display("FAIL cmov_l got valE=%0d cnd=%b want 4/1", valE, cnd);
    end
    step(4'h7, 4'h0, 64'd0, 64'd0, 64'd0);
    n_cmp++;
    if (cnd !== 1'b1) begin n_fail++; $display("FAIL jxx_always got %b want 1", cnd); end
    step(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
    n_cmp++;
    if (cnd !== 1'b0) begin n_fail++; $display("FAIL jxx_ge got %b want 0", cnd); end
    step(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
    n_cmp++;
    if (cnd !== 1'b1) begin n_fail++; $display("FAIL jxx_le got %b want 1", cnd); end
    step(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
    n_cmp++;
    if (cnd !== 1'b0) begin n_fail++; $display("FAIL jxx_g got %b want 0", cnd); end
    step(4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
    n_cmp++;
    if (cnd !== 1'b1) begin n_fail++; $display("FAIL jxx_ne got %b want 1", cnd); end
    step(4'h7, 4'h9, 64'd0, 64'd0, 64'd0);
    n_cmp++;
    if (cnd !== 1'b0) begin n_fail++; $display("FAIL jxx_ifun9 got %b want 0", cnd); end
    tick();
  endtask

  task automatic test_overflow_reset();
    step(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    n_cmp++;
    if (valE !== 64'h8000_0000_0000_0000) begin
      n_fail++;
      $display("FAIL ovf_valE got %0h want 8000000000000000", valE);
    end
    tick();
    n_cmp++;
    if (cc[2:0] !== 3'b110) begin n_fail++; $display("FAIL ovf_flags got %b want 110", cc[2:0]); end
    step(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_cc = '0;
    n_cmp++;
    if (cc !== 4'b0000) begin n_fail++; $display("FAIL midcycle_reset got %b want 0000", cc); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (cc !== 4'b0000) begin n_fail++; $display("FAIL post_reset_hold got %b want 0000", cc); end
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 64'd1;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'(int'($urandom_range(0, 31)) - 16);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    logic [3:0] ic, fn;
    for (int i = 0; i < 300; i++) begin
      ic = ($urandom_range(0, 3) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      fn = 4'($urandom_range(0, 15));
      step(ic, fn, pick_val(), pick_val(), pick_val());
      n_cmp++;
      if (valE !== exp_e) begin
        n_fail++;
        $display("FAIL rand_valE i=%0d ic=%h fn=%h got %h want %h", i, ic, fn, valE, exp_e);
      end
      n_cmp++;
      if (cnd !== exp_cnd) begin
        n_fail++;
        $display("FAIL rand_cnd i=%0d fn=%h got %b want %b", i, fn, cnd, exp_cnd);
      end
      tick();
      n_cmp++;
      if (cc !== model_cc) begin
        n_fail++;
        $display("FAIL rand_cc i=%0d ic=%h got %b want %b", i, ic, cc, model_cc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_and();
    test_stack_imm();
    test_cond();
    test_overflow_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
